// File: rtl/iter_divider_if.sv
// ---------------------------------------------------------------------------
// iter_divider_if
//   Request/response bundle between the EX stage and the iterative divider.
//   master : EX side (drives start, signed_op, dividend, divisor, cancel)
//   slave  : divider side (drives busy, done, quotient, remainder, div_by_zero)
//   WIDTH  : operand/result width in bits
// ---------------------------------------------------------------------------
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor, cancel,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor, cancel,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//   Multi-cycle radix-2 restoring divider returning quotient and remainder
//   together. Signed (truncating) or unsigned mode, divide-by-zero flag and a
//   synchronous flush (cancel). One quotient bit is produced per CALC cycle.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   div    : iter_divider_if.slave
//            start/signed_op/dividend/divisor/cancel in,
//            busy/done/quotient/remainder/div_by_zero out (all registered)
//
// Parameters
//   WIDTH  : operand/result width (>= 4)
//
// Build option
//   DIV_EARLY_TERM_EN : when defined, only bit-length(|dividend|) CALC steps
//                       are run (dividend pre-shifted to the top); results are
//                       unchanged, latency becomes n+2 edges.
// ---------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_divider_if.slave div
);

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] W_CNT = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;        // original dividend
  logic [WIDTH-1:0] b_reg;        // original divisor
  logic             signed_reg;
  logic [WIDTH-1:0] dvd_reg;      // shifts dividend out at the top, quotient in at the bottom
  logic [WIDTH-1:0] dvs_reg;      // |divisor|
  logic [WIDTH-1:0] rem_reg;      // partial remainder
  logic [CW-1:0]    count_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             dbz_reg;

  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quo_out_reg;
  logic [WIDTH-1:0] rem_out_reg;
  logic             dbz_out_reg;

  // Magnitudes of the latched operands (only folded when signed).
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  assign abs_a = (signed_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign abs_b = (signed_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  // One restoring step. The trial value needs WIDTH+1 bits because an
  // unsigned remainder up to 2^WIDTH-2 is shifted left once.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_step;
  assign trial    = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs_reg};
  assign take     = ~diff[WIDTH];
  assign rem_step = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

  // Sign fix-up. MIN / -1 wraps naturally back to MIN.
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  assign q_fix = q_neg_reg ? -dvd_reg : dvd_reg;
  assign r_fix = r_neg_reg ? -rem_reg : rem_reg;

  // Initial shift register contents and step count chosen in PREP.
  logic [WIDTH-1:0] prep_dvd;
  logic [CW-1:0]    prep_cnt;

`ifdef DIV_EARLY_TERM_EN
  logic [CW-1:0] bitlen;

  always_comb begin
    bitlen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (abs_a[i]) bitlen = CW'(i + 1);
    end
  end

  // Leading zeros are skipped; after n steps the low n bits hold the
  // quotient and the upper bits are the zeros that were shifted in.
  assign prep_cnt = bitlen;
  assign prep_dvd = abs_a << (W_CNT - bitlen);
`else
  assign prep_cnt = W_CNT;
  assign prep_dvd = abs_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      signed_reg  <= 1'b0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      count_reg   <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      dbz_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      quo_out_reg <= '0;
      rem_out_reg <= '0;
      dbz_out_reg <= 1'b0;
    end else if (div.cancel) begin
      // Flush wins over everything; published results are left untouched.
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (div.start) begin
            a_reg      <= div.dividend;
            b_reg      <= div.divisor;
            signed_reg <= div.signed_op;
            busy_reg   <= 1'b1;
            state_reg  <= S_PREP;
          end
        end
        S_PREP: begin
          dvd_reg   <= prep_dvd;
          dvs_reg   <= abs_b;
          rem_reg   <= '0;
          count_reg <= prep_cnt;
          q_neg_reg <= signed_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          r_neg_reg <= signed_reg && a_reg[WIDTH-1];
          dbz_reg   <= (b_reg == '0);
          // Zero divisor (and an empty step count) skip CALC; FIX forms the
          // result so every completion enters DONE from the same state.
          if (b_reg == '0 || prep_cnt == '0) state_reg <= S_FIX;
          else                               state_reg <= S_CALC;
        end
        S_CALC: begin
          rem_reg   <= rem_step;
          dvd_reg   <= {dvd_reg[WIDTH-2:0], take};
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) state_reg <= S_FIX;
        end
        S_FIX: begin
          if (dbz_reg) begin
            quo_out_reg <= '1;
            rem_out_reg <= a_reg;
            dbz_out_reg <= 1'b1;
          end else begin
            quo_out_reg <= q_fix;
            rem_out_reg <= r_fix;
            dbz_out_reg <= 1'b0;
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          if (!div.start) begin
            done_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign div.busy        = busy_reg;
  assign div.done        = done_reg;
  assign div.quotient    = quo_out_reg;
  assign div.remainder   = rem_out_reg;
  assign div.div_by_zero = dbz_out_reg;

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//   Directed bench for iter_divider (WIDTH=32). Stimulus pushes the expected
//   result of each operation into a queue; a monitor pops and compares when
//   done rises, including completion latency.
// ---------------------------------------------------------------------------
module tb_iter_divider;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  iter_divider_if #(.WIDTH(W)) dif ();

  iter_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  logic done_q    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected done latency: WIDTH+2 normally, n+2 with early termination,
  // 2 for a zero divisor.
  function automatic int exp_lat(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    int           n;
    m = (sgn && a[W-1]) ? -a : a;
    n = 0;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    if (b == '0) return 2;
`ifdef DIV_EARLY_TERM_EN
    return n + 2;
`else
    return (n >= 0) ? W + 2 : 0;
`endif
  endfunction

  // Monitor: compare on each rising done.
  always @(negedge clk) begin
    if (rst_n && dif.done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".q"},   64'(dif.quotient),    64'(e.q));
        chk({e.name, ".r"},   64'(dif.remainder),   64'(e.r));
        chk({e.name, ".dbz"}, 64'(dif.div_by_zero), 64'(e.dbz));
        chk({e.name, ".lat"}, 64'(cyc - e.acc),     64'(e.lat));
        $display("op %s: q=%h r=%h dbz=%0d lat=%0d", e.name, dif.quotient,
                 dif.remainder, dif.div_by_zero, cyc - e.acc);
      end
    end
    done_q <= dif.done;
  end

  task automatic do_op(input string name, input bit sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] q,
                       input logic [W-1:0] r, input bit dbz, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    dif.start     = 1'b1;
    dif.signed_op = sgn;
    dif.dividend  = a;
    dif.divisor   = b;
    e.q = q; e.r = r; e.dbz = dbz; e.name = name;
    e.lat = exp_lat(sgn, a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    // Scramble operands after acceptance; they must be ignored.
    @(negedge clk);
    dif.dividend = ~a;
    dif.divisor  = b + 32'd3;
    dif.signed_op = ~sgn;
    n = 1;
    while (!dif.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dif.done) chk({name, ".timeout"}, 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, ".hold_done"}, 64'(dif.done), 64'd1);
      chk({name, ".hold_busy"}, 64'(dif.busy), 64'd0);
      chk({name, ".hold_q"},    64'(dif.quotient), 64'(q));
    end
    dif.start = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    dif.start     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.cancel    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(dif.busy), 64'd0);
    chk("rst.done", 64'(dif.done), 64'd0);
    chk("rst.q",    64'(dif.quotient), 64'd0);
    chk("rst.r",    64'(dif.remainder), 64'd0);
    chk("rst.dbz",  64'(dif.div_by_zero), 64'd0);
    rst_n = 1'b1;

    do_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 0);
    do_op("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 0);
    do_op("u-7_2",    1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 0);
    do_op("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 0);
    do_op("s-7_-2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 0);
    do_op("smin_-1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 0);
    do_op("umax_1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 0);
    do_op("s-5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 0);
    do_op("u5_0",     1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 0);

    // Cancel during the 10th CALC cycle of 1000/3.
    @(negedge clk);
    dif.start     = 1'b1;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'd1000;
    dif.divisor   = 32'd3;
    repeat (11) @(negedge clk);
    dif.cancel = 1'b1;
    dif.start  = 1'b0;
    @(negedge clk);
    dif.cancel = 1'b0;
    chk("cancel.busy", 64'(dif.busy), 64'd0);
    chk("cancel.done", 64'(dif.done), 64'd0);
    chk("cancel.q",    64'(dif.quotient), 64'hFFFFFFFF);
    chk("cancel.r",    64'(dif.remainder), 64'd5);

    // cancel together with start in IDLE drops the request.
    @(negedge clk);
    dif.start  = 1'b1;
    dif.cancel = 1'b1;
    @(negedge clk);
    dif.start  = 1'b0;
    dif.cancel = 1'b0;
    chk("cancel_idle.busy", 64'(dif.busy), 64'd0);

    // Hold start through DONE, then back-to-back ops.
    do_op("u9_3",     1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 5);
    do_op("u1_1",     1'b0, 32'd1,          32'd1,          32'd1,          32'd0,          1'b0, 0);
    do_op("u0_7",     1'b0, 32'd0,          32'd7,          32'd0,          32'd0,          1'b0, 0);

    // Asynchronous reset in the middle of CALC clears outputs at once.
    @(negedge clk);
    dif.start     = 1'b1;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'd100;
    dif.divisor   = 32'd7;
    repeat (6) @(negedge clk);
    chk("mid.busy", 64'(dif.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(dif.busy), 64'd0);
    chk("arst.done", 64'(dif.done), 64'd0);
    chk("arst.q",    64'(dif.quotient), 64'd0);
    chk("arst.dbz",  64'(dif.div_by_zero), 64'd0);
    dif.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op("u1000_3",  1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
